scan_capture4b4: RTL and testbench

SCAN_CAPTURE4B4 -- requirements
Module: scan_capture4b4

---
 rtl/scan_capture4b4_if.sv | 29 ++
 rtl/scan_capture4b4.sv | 113 +++++++++++
 tb/tb_scan_capture4b4.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/scan_capture4b4_if.sv
// Scan/capture bus between the channel scanner and its environment.
//   start, continuous : scan requests into the scanner
//   S                 : channel select out to the downstream 4:1 4-bit mux
//   Y                 : mux output for the currently driven S
//   frame, frame_valid: captured 4-channel frame and its valid flag
//   frame_ready       : consumer acceptance
//   busy              : scanner not idle
interface scan_capture4b4_if;
    logic        start;
    logic        continuous;
    logic [1:0]  S;
    logic [3:0]  Y;
    logic [15:0] frame;
    logic        frame_valid;
    logic        frame_ready;
    logic        busy;

    // Scanner side
    modport master (
        input  start, continuous, Y, frame_ready,
        output S, frame, frame_valid, busy
    );

    // Environment side (requester, mux, consumer)
    modport slave (
        output start, continuous, Y, frame_ready,
        input  S, frame, frame_valid, busy
    );
endinterface

// File: rtl/scan_capture4b4.sv
// Sequentially selects channels 0..3 of an external 4:1 4-bit mux, holds
// each select for DWELL cycles, samples Y on the last cycle of each dwell
// and presents the assembled 16-bit frame with a valid/ready handshake.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : scan_capture4b4_if.master (start, continuous, S, Y, frame,
//           frame_valid, frame_ready, busy)
// DWELL legal range is 1..16.
module scan_capture4b4 #(
    parameter int unsigned DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    scan_capture4b4_if.master      bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      frame_q, frame_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    // Next-state, select, dwell counter and frame capture
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    s_d     = 2'd0;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (cnt_q == CNT_LAST) begin
                    // Last dwell cycle of this channel: capture Y into its slot
                    cnt_d = '0;
                    case (s_q)
                        2'd0:    frame_d[3:0]   = bus.Y;
                        2'd1:    frame_d[7:4]   = bus.Y;
                        2'd2:    frame_d[11:8]  = bus.Y;
                        default: frame_d[15:12] = bus.Y;
                    endcase
                    if (s_q == 2'd3) begin
                        state_d = HOLD;
                        s_d     = 2'd0;
                    end else begin
                        s_d = s_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                // continuous only matters at the accepting edge
                if (bus.frame_ready) begin
                    state_d = bus.continuous ? SCAN : IDLE;
                    s_d     = 2'd0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = 2'd0;
                cnt_d   = '0;
            end
        endcase

        // Status flags registered from the next state
        valid_d = (state_d == HOLD);
        busy_d  = (state_d != IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= 2'd0;
            cnt_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.S           = s_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = valid_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_scan_capture4b4.sv
// Bench for scan_capture4b4: one instance with DWELL=4 and one with DWELL=1,
// each driven by a behavioural 4:1 mux. Expected frames are queued when a
// scan is requested and checked by a monitor on every accepted frame.
module tb_scan_capture4b4;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    logic [3:0]  da [4];
    logic [3:0]  db [4];
    logic [15:0] qa [$];
    logic [15:0] qb [$];

    scan_capture4b4_if ifa ();
    scan_capture4b4_if ifb ();

    scan_capture4b4 #(.DWELL(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    scan_capture4b4 #(.DWELL(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    // Behavioural downstream muxes
    assign ifa.Y = da[ifa.S];
    assign ifb.Y = db[ifb.S];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: values read 1 time unit after the falling edge are what the
    // next rising edge will see, so valid&&ready here means acceptance.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && ifa.frame_valid && ifa.frame_ready) begin
            if (qa.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL frame_a_unexpected: got %0h expected none", ifa.frame);
            end else begin
                chk("frame_a", 32'(ifa.frame), 32'(qa.pop_front()));
            end
        end
        if (rst_n && ifb.frame_valid && ifb.frame_ready) begin
            if (qb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL frame_b_unexpected: got %0h expected none", ifb.frame);
            end else begin
                chk("frame_b", 32'(ifb.frame), 32'(qb.pop_front()));
            end
        end
    end

    // Single scan on instance A with per-cycle select checks; optional
    // re-pulse of start while channel 2 is selected.
    task automatic run_a(input logic [15:0] exp, input bit repulse);
        qa.push_back(exp);
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("s_a", 32'(ifa.S), 32'(i / 4));
            chk("busy_a_scan", 32'(ifa.busy), 32'd1);
            chk("valid_a_scan", 32'(ifa.frame_valid), 32'd0);
            if (repulse && i == 9)  ifa.start = 1'b1;
            if (repulse && i == 10) ifa.start = 1'b0;
            @(negedge clk);
        end
        chk("valid_a_at_latency", 32'(ifa.frame_valid), 32'd1);
        chk("frame_a_at_latency", 32'(ifa.frame), 32'(exp));
        @(negedge clk);
        chk("busy_a_after_accept", 32'(ifa.busy), 32'd0);
        chk("valid_a_after_accept", 32'(ifa.frame_valid), 32'd0);
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        ifa.start = 1'b0; ifa.continuous = 1'b0; ifa.frame_ready = 1'b0;
        ifb.start = 1'b0; ifb.continuous = 1'b0; ifb.frame_ready = 1'b0;
        da[0] = 4'h1; da[1] = 4'h2; da[2] = 4'h3; da[3] = 4'h4;
        db[0] = 4'hA; db[1] = 4'hB; db[2] = 4'hC; db[3] = 4'hD;

        repeat (2) @(negedge clk);
        chk("rst_s_a", 32'(ifa.S), 32'd0);
        chk("rst_frame_a", 32'(ifa.frame), 32'd0);
        chk("rst_valid_a", 32'(ifa.frame_valid), 32'd0);
        chk("rst_busy_a", 32'(ifa.busy), 32'd0);
        chk("rst_valid_b", 32'(ifb.frame_valid), 32'd0);
        rst_n = 1'b1;

        // Basic scan, DWELL=4
        ifa.frame_ready = 1'b1;
        run_a(16'h4321, 1'b0);

        // start re-pulsed while channel 2 selected is ignored
        da[0] = 4'h5;
        run_a(16'h4325, 1'b1);

        // Idle with frame_ready high: nothing happens, frame retained
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_valid_a", 32'(ifa.frame_valid), 32'd0);
            chk("idle_s_a", 32'(ifa.S), 32'd0);
        end
        chk("idle_frame_a", 32'(ifa.frame), 32'h4325);

        // Continuous back-to-back frames
        da[0] = 4'h1;
        ifa.continuous = 1'b1;
        qa.push_back(16'h4321);
        qa.push_back(16'h4329);
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        n = 0;
        while (!ifa.frame_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("cont_latency", 32'(n), 32'd16);
        @(negedge clk);
        da[0] = 4'h9;
        ifa.continuous = 1'b0;
        n = 0;
        while (!ifa.frame_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("cont_gap", 32'(n), 32'd16);
        @(negedge clk);
        chk("cont_busy_end", 32'(ifa.busy), 32'd0);

        // DWELL=1 with a stalled consumer
        qb.push_back(16'hDCBA);
        @(negedge clk);
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        n = 0;
        while (!ifb.frame_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("b_latency", 32'(n), 32'd4);
        for (int i = 0; i < 10; i++) begin
            chk("b_hold_valid", 32'(ifb.frame_valid), 32'd1);
            chk("b_hold_frame", 32'(ifb.frame), 32'hDCBA);
            chk("b_hold_busy", 32'(ifb.busy), 32'd1);
            @(negedge clk);
        end
        ifb.frame_ready = 1'b1;
        @(negedge clk);
        chk("b_valid_after_accept", 32'(ifb.frame_valid), 32'd0);
        chk("b_busy_after_accept", 32'(ifb.busy), 32'd0);
        ifb.frame_ready = 1'b0;

        // Asynchronous reset mid-scan at channel 2
        @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_s_a", 32'(ifa.S), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_s_a", 32'(ifa.S), 32'd0);
        chk("async_rst_frame_a", 32'(ifa.frame), 32'd0);
        chk("async_rst_busy_a", 32'(ifa.busy), 32'd0);
        chk("async_rst_frame_b", 32'(ifb.frame), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("post_rst_valid_a", 32'(ifa.frame_valid), 32'd0);
            chk("post_rst_busy_a", 32'(ifa.busy), 32'd0);
        end

        chk("queue_a_drained", 32'(qa.size()), 32'd0);
        chk("queue_b_drained", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
